// File: rtl/lsu_bus_ctrl.sv
// Sequential load/store unit bus controller.
// Takes one request at a time, decodes it against the slave regions, checks
// alignment, runs a single bus access with an acknowledge timeout and returns
// extended load data or an error code to the memory stage.
module lsu_bus_ctrl #(
  parameter int                         NUM_REGIONS  = 3,
  parameter logic [32*NUM_REGIONS-1:0] REGION_BASE  = {32'h0000_3000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [32*NUM_REGIONS-1:0] REGION_LIMIT = {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_0FFF},
  parameter int                         TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  input  logic                        req_we,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  output logic [1:0]                  rsp_err_code,
  output logic [NUM_REGIONS-1:0]      bus_sel,
  output logic [31:0]                 bus_addr,
  output logic                        bus_we,
  output logic [31:0]                 bus_wdata,
  output logic [3:0]                  bus_wstrb,
  input  logic [NUM_REGIONS-1:0]      bus_ack,
  input  logic [32*NUM_REGIONS-1:0]   bus_rdata
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]             cap_lsb;
  logic                   cap_we;
  logic [1:0]             cap_size;
  logic                   cap_uns;
  logic [1:0]             err_code;
  logic [TIMER_W-1:0]     timer;
  logic [31:0]            rdata_lat;

  logic                   misalign;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [31:0]            lane_wdata;
  logic [3:0]             lane_strb;
  logic                   ack_hit;
  logic [31:0]            ack_rdata;
  logic                   timed_out;
  logic [31:0]            shifted;
  logic [31:0]            load_data;

  // Request decode: alignment check, lowest-index region match, lane steering
  always_comb begin
    misalign = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    hit_sel = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (req_addr >= REGION_BASE[32*i +: 32] && req_addr <= REGION_LIMIT[32*i +: 32]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
    case (req_size)
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_strb  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_strb  = 4'b0011 << req_addr[1:0];
      end
      default: begin
        lane_wdata = req_wdata;
        lane_strb  = 4'b1111;
      end
    endcase
  end

  // Acknowledge and read-word selection for the currently selected slave
  always_comb begin
    ack_hit   = |(bus_ack & bus_sel);
    ack_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (bus_sel[i]) ack_rdata = bus_rdata[32*i +: 32];
    end
    timed_out = (timer == TIMER_W'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (misalign || hit_sel == '0) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (ack_hit || timed_out) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, bus drive, timer and read-word latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_lsb   <= '0;
      cap_we    <= 1'b0;
      cap_size  <= '0;
      cap_uns   <= 1'b0;
      err_code  <= '0;
      timer     <= '0;
      rdata_lat <= '0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_lsb   <= req_addr[1:0];
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            timer     <= '0;
            rdata_lat <= '0;
            if (misalign) begin
              err_code <= 2'b10;
            end else if (hit_sel == '0) begin
              err_code <= 2'b01;
            end else begin
              err_code  <= 2'b00;
              bus_sel   <= hit_sel;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_we    <= req_we;
              bus_wdata <= lane_wdata;
              bus_wstrb <= req_we ? lane_strb : 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (ack_hit || timed_out) begin
            if (ack_hit) rdata_lat <= ack_rdata;
            else         err_code  <= 2'b11;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response formatting: lane extraction and sign/zero extension
  always_comb begin
    shifted = rdata_lat >> {cap_lsb, 3'b000};
    case (cap_size)
      2'b00:   load_data = cap_uns ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = cap_uns ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rdata_lat;
    endcase
    rsp_err      = (state == RESP) && (err_code != 2'b00);
    rsp_err_code = (state == RESP) ? err_code : 2'b00;
    rsp_rdata    = (state == RESP && err_code == 2'b00 && !cap_we) ? load_data : 32'b0;
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed testbench for lsu_bus_ctrl with a response scoreboard.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;
  logic [2:0]  bus_sel;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [2:0]  bus_ack;
  logic [95:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] rdata;
    int          latency;
  } exp_t;

  exp_t sb[$];

  lsu_bus_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_err_code (rsp_err_code),
    .bus_sel      (bus_sel),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it for the accepting edge
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic we,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    req_addr     = addr;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Compare the produced response against the oldest scoreboard entry
  task automatic checkOutput(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, lat, e.latency);
      check({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, (e.code != 2'b00)});
      check({tag, " err_code"}, {30'b0, rsp_err_code}, {30'b0, e.code});
      check({tag, " rdata"}, rsp_rdata, e.rdata);
      check({tag, " sel_at_rsp"}, {29'b0, bus_sel}, 32'd0);
    end
  endtask

  // Full transaction: push expectation, drive request, play the slave, check response
  task automatic doTransaction(input string tag, input logic [31:0] addr, input logic we,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                               input int ack_delay, input logic [2:0] wrong_mask,
                               input logic [31:0] ack_rdata, input logic [2:0] exp_sel,
                               input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                               input int exp_sel_cycles, input logic [1:0] exp_code,
                               input logic [31:0] exp_rdata, input int exp_lat);
    exp_t e;
    int   lat;
    int   sel_cycles;
    bit   stable;
    e.code    = exp_code;
    e.rdata   = exp_rdata;
    e.latency = exp_lat;
    sb.push_back(e);
    for (int i = 0; i < 3; i++) bus_rdata[32*i +: 32] = exp_sel[i] ? ack_rdata : ~ack_rdata;
    applyStimulus(tag, addr, we, size, uns, wdata);
    lat        = 1;
    sel_cycles = 0;
    stable     = 1'b1;
    while (!rsp_valid && lat <= 40) begin
      if (bus_sel != 3'b000) sel_cycles++;
      if (bus_sel !== exp_sel || bus_addr !== {addr[31:2], 2'b00}) stable = 1'b0;
      if (lat == 1) begin
        check({tag, " bus_sel"}, {29'b0, bus_sel}, {29'b0, exp_sel});
        check({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        check({tag, " bus_we"}, {31'b0, bus_we}, {31'b0, we});
        check({tag, " bus_wstrb"}, {28'b0, bus_wstrb}, {28'b0, exp_wstrb});
        if (we) check({tag, " bus_wdata"}, bus_wdata, exp_wdata);
      end
      bus_ack = wrong_mask | ((ack_delay >= 0 && lat - 1 == ack_delay) ? exp_sel : 3'b000);
      step();
      bus_ack = 3'b000;
      lat++;
    end
    check({tag, " rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid) checkOutput(tag, lat);
    else           void'(sb.pop_front());
    check({tag, " sel_cycles"}, sel_cycles, exp_sel_cycles);
    if (exp_sel_cycles > 0) check({tag, " sel_stable"}, {31'b0, stable}, 32'd1);
    step();
    check({tag, " rsp_one_cycle"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    bus_ack      = '0;
    bus_rdata    = '0;
    step();
    step();
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset bus_sel", {29'b0, bus_sel}, 32'd0);
    check("reset bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] directed accesses");
    doTransaction("word_load", 32'h0000_1004, 1'b0, 2'b10, 1'b0, 32'h0, 0, 3'b000,
                  32'hDEAD_BEEF, 3'b010, 4'b0000, 32'h0, 1, 2'b00, 32'hDEAD_BEEF, 2);
    doTransaction("lb_signed", 32'h0000_1003, 1'b0, 2'b00, 1'b0, 32'h0, 0, 3'b000,
                  32'h80FF_FF7F, 3'b010, 4'b0000, 32'h0, 1, 2'b00, 32'hFFFF_FF80, 2);
    doTransaction("lbu", 32'h0000_1003, 1'b0, 2'b00, 1'b1, 32'h0, 0, 3'b000,
                  32'h80FF_FF7F, 3'b010, 4'b0000, 32'h0, 1, 2'b00, 32'h0000_0080, 2);
    doTransaction("half_store", 32'h0000_3002, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD, 0, 3'b000,
                  32'h5555_5555, 3'b100, 4'b1100, 32'hABCD_ABCD, 1, 2'b00, 32'h0, 2);
    doTransaction("byte_store", 32'h0000_0001, 1'b1, 2'b00, 1'b0, 32'h1234_56A5, 1, 3'b000,
                  32'h0, 3'b001, 4'b0010, 32'hA5A5_A5A5, 2, 2'b00, 32'h0, 3);
    doTransaction("lh_signed", 32'h0000_0002, 1'b0, 2'b01, 1'b0, 32'h0, 1, 3'b000,
                  32'h8001_0000, 3'b001, 4'b0000, 32'h0, 2, 2'b00, 32'hFFFF_8001, 3);

    $display("[TB] error responses");
    doTransaction("unmapped", 32'h0000_4000, 1'b0, 2'b10, 1'b0, 32'h0, 0, 3'b000,
                  32'h0, 3'b000, 4'b0000, 32'h0, 0, 2'b01, 32'h0, 1);
    doTransaction("misalign_word", 32'h0000_1002, 1'b0, 2'b10, 1'b0, 32'h0, 0, 3'b000,
                  32'h0, 3'b000, 4'b0000, 32'h0, 0, 2'b10, 32'h0, 1);
    doTransaction("size_11", 32'h0000_1000, 1'b0, 2'b11, 1'b0, 32'h0, 0, 3'b000,
                  32'h0, 3'b000, 4'b0000, 32'h0, 0, 2'b10, 32'h0, 1);
    doTransaction("misalign_half", 32'h0000_1001, 1'b1, 2'b01, 1'b0, 32'h0, 0, 3'b000,
                  32'h0, 3'b000, 4'b0000, 32'h0, 0, 2'b10, 32'h0, 1);

    $display("[TB] timeout and ack edge cases");
    doTransaction("timeout", 32'h0000_0000, 1'b0, 2'b10, 1'b0, 32'h0, -1, 3'b000,
                  32'h0, 3'b001, 4'b0000, 32'h0, 16, 2'b11, 32'h0, 17);
    doTransaction("ack_at_16", 32'h0000_0004, 1'b0, 2'b10, 1'b0, 32'h0, 15, 3'b000,
                  32'hCAFE_F00D, 3'b001, 4'b0000, 32'h0, 16, 2'b00, 32'hCAFE_F00D, 17);
    doTransaction("wrong_ack", 32'h0000_2000, 1'b0, 2'b10, 1'b0, 32'h0, 3, 3'b101,
                  32'h1234_5678, 3'b010, 4'b0000, 32'h0, 4, 2'b00, 32'h1234_5678, 5);

    $display("[TB] reset during access");
    applyStimulus("mid_reset", 32'h0000_0008, 1'b0, 2'b10, 1'b0, 32'h0);
    step();
    check("mid_reset sel_before", {29'b0, bus_sel}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_reset sel_after", {29'b0, bus_sel}, 32'd0);
    check("mid_reset ready_after", {31'b0, req_ready}, 32'd1);
    check("mid_reset no_rsp", {31'b0, rsp_valid}, 32'd0);
    step();
    check("mid_reset no_rsp_later", {31'b0, rsp_valid}, 32'd0);
    step();
    check("mid_reset still_idle", {31'b0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Sequential load/store unit. Accepts one memory request at a time through a valid/ready handshake.
- Decodes the address against NUM_REGIONS parametrised regions and checks alignment for byte, half and word accesses.
- Drives a one-hot select bus to the memory and peripheral slaves and waits for a per-region acknowledge, with a timeout.
- Returns sign- or zero-extended read data, or an error code, to the pipeline memory stage.

Parameters:
- NUM_REGIONS, 3, number of decoded slave regions; region i maps to bus_sel[i].
- REGION_BASE, {32'h0000_3000, 32'h0000_1000, 32'h0000_0000}, packed 32*NUM_REGIONS; inclusive base address of each region, region 0 in the LSBs.
- REGION_LIMIT, {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_0FFF}, packed 32*NUM_REGIONS; inclusive last address of each region.
- TIMEOUT, 16, number of ACCESS cycles without an acknowledge before a timeout error; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load data (LBU/LHU)
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request failed
- rsp_err_code  out  2  00 none, 01 unmapped, 10 misaligned or illegal size, 11 timeout
- bus_sel  out  NUM_REGIONS  one-hot slave select
- bus_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
- bus_we  out  1  write enable
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes; 0 on reads
- bus_ack  in  NUM_REGIONS  per-slave completion
- bus_rdata  in  32*NUM_REGIONS  per-slave read word, region 0 in the LSBs

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Timer and captured request are cleared.
  - Reset mid-ACCESS drops bus_sel on the next edge, and no response is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture addr, we, size, unsigned and wdata.
  - Check order, first match wins:
    - size 11, or half with addr[0] = 1, or word with addr[1:0] != 0 -> RESP with code 10.
    - else no region with BASE <= addr <= LIMIT -> RESP with code 01.
    - else -> ACCESS.
  - Overlapping regions: the lowest index wins.
  - Only the start address is range-checked.
- ACCESS:
  - req_ready = 0.
  - bus_sel, bus_addr, bus_we, bus_wdata and bus_wstrb are registered and held stable for the whole state.
  - The timer starts at 0 and increments each cycle.
  - bus_ack of the selected region -> latch its bus_rdata, deassert bus_sel, go to RESP.
  - Acks from non-selected regions are ignored.
  - Timer == TIMEOUT-1 with no ack -> deassert bus_sel, go to RESP with code 11.
  - An ack in the same cycle as the timeout wins (no error).
- RESP:
  - rsp_valid = 1 for exactly one cycle; the consumer has no backpressure.
  - rsp_err = (code != 0); then return to IDLE.
  - req_ready stays 0 in RESP, so the next request is accepted no earlier than the cycle after rsp_valid.
- Latency:
  - Error responses: rsp_valid 1 cycle after acceptance.
  - Good access with same-cycle ack: rsp_valid 2 cycles after acceptance.
  - Each extra wait cycle adds 1.
- Write lanes:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << addr[1:0].
  - word: wdata unchanged, wstrb = 1111.
- Read extraction:
  - Shift the latched word right by 8*addr[1:0], take 8 or 16 bits.
  - Sign-extend unless req_unsigned; word loads are passed through.
  - rsp_rdata = 0 on stores and on any error.
- Errored requests never assert bus_sel.

Test Plan:
- Word load 0x0000_1004, DMEM ack in the first ACCESS cycle with rdata 0xDEADBEEF -> bus_sel = 010; rsp_valid 2 cycles after acceptance; rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Signed byte load 0x0000_1003, rdata 0x80FF_FF7F -> 0xFFFF_FF80; the same access with req_unsigned = 1 -> 0x0000_0080.
- Half store 0x0000_3002, wdata 0x0000_ABCD -> bus_sel = 100, bus_wstrb = 1100, bus_wdata = 0xABCD_ABCD; response with rsp_err = 0 and rsp_rdata = 0.
- Errors:
  - Load 0x0000_4000 -> code 01.
  - Word load 0x0000_1002 -> code 10.
  - Size 11 -> code 10.
  - Each error response arrives 1 cycle after acceptance with bus_sel never asserted.
- Slave never acks, TIMEOUT = 16 -> bus_sel high for exactly 16 cycles; rsp_err_code = 11.
- Edge cases:
  - Ack arriving on cycle 16 -> success instead of timeout.
  - Ack on a non-selected region -> ignored.
  - rst_n low mid-ACCESS -> bus_sel = 0 and req_ready = 1 after the edge, with no rsp_valid.
